// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: accepts one vector request, walks it element by element through
// a shared scalar ALU lane, and returns the collected results and flags as one response.
module vec_alu_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] d_result,
    input  logic [3:0]       d_flags,
    output logic [WIDTH-1:0] q_result,
    output logic [3:0]       q_flags
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_result <= '0;
            q_flags  <= '0;
        end else if (clr) begin
            q_result <= '0;
            q_flags  <= '0;
        end else if (we) begin
            q_result <= d_result;
            q_flags  <= d_flags;
        end
    end
endmodule

module vec_alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int VLEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_opcode,
    input  logic [VLEN*WIDTH-1:0] req_a,
    input  logic [VLEN*WIDTH-1:0] req_b,
    input  logic [VLEN*WIDTH-1:0] req_c,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [WIDTH-1:0]      alu_c,
    output logic [2:0]            alu_opcode,
    output logic [$clog2(VLEN)-1:0] alu_lane,
    input  logic [WIDTH-1:0]      alu_result,
    input  logic [3:0]            alu_flags,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [VLEN*WIDTH-1:0] resp_data,
    output logic [VLEN*4-1:0]     resp_lane_flags,
    output logic [3:0]            resp_flags,
    output logic                  resp_err,
    output logic                  busy
);
    localparam int IDXW = $clog2(VLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_NOP = 3'b011;

    typedef struct packed {
        logic [2:0]                  opcode;
        logic [VLEN-1:0][WIDTH-1:0]  a;
        logic [VLEN-1:0][WIDTH-1:0]  b;
        logic [VLEN-1:0][WIDTH-1:0]  c;
    } req_t;

    logic [1:0]                 state;
    logic [IDXW-1:0]            idx;
    req_t                       req_q;
    logic [VLEN-1:0][WIDTH-1:0] res_q;
    logic [VLEN-1:0][3:0]       flg_q;
    logic                       accept;
    logic                       run;
    logic                       op_ok;
    logic                       last;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = req_valid && req_ready;
    assign run       = (state == S_RUN);
    assign last      = (idx == IDXW'(VLEN-1));
    assign op_ok     = (req_opcode == 3'b000) || (req_opcode == 3'b001) ||
                       (req_opcode == 3'b010) || (req_opcode == 3'b111);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            req_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    req_q <= '{opcode: req_opcode, a: req_a, b: req_b, c: req_c};
                    idx   <= '0;
                    state <= op_ok ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (last) state <= S_DONE;
                    else      idx   <= idx + 1'b1;
                end
                S_DONE: if (resp_valid && resp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // One result slot per element; the slot whose index matches idx captures the ALU.
    for (genvar g = 0; g < VLEN; g++) begin : g_slot
        vec_alu_slot #(.WIDTH(WIDTH)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .clr      (accept),
            .we       (run && (idx == IDXW'(g))),
            .d_result (alu_result),
            .d_flags  (alu_flags),
            .q_result (res_q[g]),
            .q_flags  (flg_q[g])
        );
    end

    assign alu_a      = run ? req_q.a[idx] : '0;
    assign alu_b      = run ? req_q.b[idx] : '0;
    assign alu_c      = run ? req_q.c[idx] : '0;
    assign alu_opcode = run ? req_q.opcode : OP_NOP;
    assign alu_lane   = run ? idx : '0;

    // resp_valid trails entry into DONE by one edge so the last slot write is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                resp_valid <= 1'b0;
                resp_err   <= !op_ok;
            end else if (state == S_DONE && !resp_valid) begin
                resp_valid <= 1'b1;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    assign resp_data       = res_q;
    assign resp_lane_flags = flg_q;

    // Aggregate {V,N,Z,C}: Z only when every element is zero, others if any element sets them.
    always_comb begin
        resp_flags = 4'b0010;
        for (int i = 0; i < VLEN; i++) begin
            resp_flags[0] = resp_flags[0] | flg_q[i][0];
            resp_flags[1] = resp_flags[1] & flg_q[i][1];
            resp_flags[2] = resp_flags[2] | flg_q[i][2];
            resp_flags[3] = resp_flags[3] | flg_q[i][3];
        end
    end
endmodule
